// File: rtl/sc_stream_gen.sv
// Stochastic stream generator: steps an external LFSR for 2^LEN_LOG2 cycles and emits rand < operand per cycle.
// Optional ones counter enabled by defining SC_COUNT_EN; otherwise result is tied to zero.
module sc_stream_gen #(
   parameter int WIDTH    = 8,
   parameter int LEN_LOG2 = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_value,
   output logic                lfsr_en,
   input  logic [WIDTH-1:0]    rand_data,   // LFSR data; "rand" is a reserved keyword
   output logic                sbit,
   output logic                sbit_valid,
   output logic [LEN_LOG2:0]   result,
   output logic                result_valid
);

   // state | meaning
   // IDLE  | waiting for an operand, in_ready high
   // RUN   | LFSR stepping, one comparison per cycle for N cycles
   // DONE  | one-cycle end-of-stream, result_valid high
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [LEN_LOG2:0] CNT_LAST = {1'b0, {LEN_LOG2{1'b1}}};

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    op_q;
   logic [LEN_LOG2:0]   cnt;
   logic                hit;

   assign hit = (rand_data < op_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = S_RUN;
         S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q       <= '0;
         cnt        <= '0;
         sbit       <= 1'b0;
         sbit_valid <= 1'b0;
      end else begin
         if (state == S_IDLE && in_valid) begin
            op_q <= in_value;
            cnt  <= '0;
         end
         if (state == S_RUN) begin
            sbit       <= hit;
            sbit_valid <= 1'b1;
            cnt        <= cnt + 1'b1;
         end else begin
            sbit       <= 1'b0;
            sbit_valid <= 1'b0;
         end
      end
   end

`ifdef SC_COUNT_EN
   logic [LEN_LOG2:0] ones;

   // Maximum is N, which fits in LEN_LOG2+1 bits, so no saturation logic is needed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          ones <= '0;
      else if (state == S_IDLE && in_valid) ones <= '0;
      else if (state == S_RUN)             ones <= ones + {{LEN_LOG2{1'b0}}, hit};
   end

   always_comb begin
      in_ready     = (state == S_IDLE);
      lfsr_en      = (state == S_RUN);
      result_valid = (state == S_DONE);
      result       = (state == S_DONE) ? ones : '0;
   end
`else
   always_comb begin
      in_ready     = (state == S_IDLE);
      lfsr_en      = (state == S_RUN);
      result_valid = (state == S_DONE);
      result       = '0;
   end
`endif

endmodule
